// File: rtl/gate_sweep_ctrl.sv
// Sequencer that walks a 3-input gate through all 8 input vectors, waits SETTLE
// cycles per vector, captures the output into a truth table and scores it.
module gate_sweep_ctrl #(
    parameter int unsigned SETTLE = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] exp_tt,
    output logic       gate_a,
    output logic       gate_b,
    output logic       gate_c,
    input  logic       gate_o,
    output logic       busy,
    output logic       done,
    output logic [7:0] tt,
    output logic [3:0] err_cnt,
    output logic       pass,
    output logic [2:0] state_dbg   // current FSM state; 0 = IDLE
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_DRIVE  = 3'd1,
        S_SETTLE = 3'd2,
        S_SAMPLE = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    localparam logic [3:0] SETTLE_LD = 4'(SETTLE);

    state_t     state_q, state_d;
    logic [2:0] idx_q, idx_d;
    logic [3:0] cnt_q;
    logic [7:0] exp_q;
    logic [7:0] tt_q;
    logic [3:0] err_q;
    logic       pass_q;
    logic [2:0] gate_q;
    logic       accept;
    logic       sample_en;
    logic       miss;

    // Handshake: start is a level request looked at only in IDLE; a start seen
    // there is accepted at that edge, anything seen in other states is dropped.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        accept    = 1'b0;
        sample_en = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    accept  = 1'b1;
                    idx_d   = 3'd0;
                    state_d = S_DRIVE;
                end
            end
            S_DRIVE:  state_d = S_SETTLE;
            S_SETTLE: begin
                if (cnt_q == 4'd1) begin
                    state_d = S_SAMPLE;
                end
            end
            S_SAMPLE: begin
                sample_en = 1'b1;
                if (idx_q == 3'd7) begin
                    state_d = S_DONE;
                end else begin
                    idx_d   = idx_q + 3'd1;
                    state_d = S_DRIVE;
                end
            end
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    assign miss = (gate_o != exp_q[idx_q]);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            idx_q   <= 3'd0;
            cnt_q   <= 4'd0;
            exp_q   <= 8'd0;
            tt_q    <= 8'd0;
            err_q   <= 4'd0;
            pass_q  <= 1'b0;
            gate_q  <= 3'd0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;

            if (accept) begin
                exp_q  <= exp_tt;
                tt_q   <= 8'd0;
                err_q  <= 4'd0;
                pass_q <= 1'b0;
            end

            if (state_q == S_DRIVE) begin
                cnt_q <= SETTLE_LD;
            end else if (state_q == S_SETTLE && cnt_q != 4'd1) begin
                cnt_q <= cnt_q - 4'd1;
            end

            if (sample_en) begin
                tt_q[idx_q] <= gate_o;
                if (miss) begin
                    err_q <= err_q + 4'd1;
                end
            end

            // err_q already holds the last sample's contribution by DONE.
            if (state_q == S_DONE) begin
                pass_q <= (err_q == 4'd0);
            end

            // Gate inputs move only when a vector is launched or the sweep ends.
            if (state_d == S_DRIVE) begin
                gate_q <= idx_d;
            end else if (state_d == S_IDLE) begin
                gate_q <= 3'd0;
            end
        end
    end

    assign gate_a    = gate_q[2];
    assign gate_b    = gate_q[1];
    assign gate_c    = gate_q[0];
    assign busy      = (state_q == S_DRIVE) || (state_q == S_SETTLE) || (state_q == S_SAMPLE);
    assign done      = (state_q == S_DONE);
    assign tt        = tt_q;
    assign err_cnt   = err_q;
    assign pass      = pass_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_gate_sweep_ctrl.sv
// Bench for gate_sweep_ctrl: one instance with SETTLE=2 and a combinational gate,
// one with SETTLE=1 and a registered gate, checked against a truth-table model.
module tb_gate_sweep_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       start;
    logic       sel;
    logic [7:0] exp_tt;
    logic [1:0] gmode;
    logic [7:0] rand_tt;
    int         checks = 0;
    int         errors = 0;

    logic       start0, start1;
    logic       g0_a, g0_b, g0_c, g0_o, busy0, done0, pass0;
    logic       g1_a, g1_b, g1_c, g1_o, busy1, done1, pass1;
    logic [7:0] tt0, tt1;
    logic [3:0] err0, err1;
    logic [2:0] st0, st1;

    // mode 0: exactly-two-of-three, mode 1: stuck at 1, mode 2: arbitrary table
    function automatic logic gate_fn(input logic [1:0] mode, input logic [2:0] v,
                                     input logic [7:0] tbl);
        case (mode)
            2'd0:    return ($countones(v) == 2);
            2'd1:    return 1'b1;
            default: return tbl[v];
        endcase
    endfunction

    assign start0 = start & ~sel;
    assign start1 = start & sel;
    assign g0_o   = gate_fn(gmode, {g0_a, g0_b, g0_c}, rand_tt);
    always_ff @(posedge clk) g1_o <= gate_fn(2'd0, {g1_a, g1_b, g1_c}, rand_tt);

    gate_sweep_ctrl #(.SETTLE(2)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .exp_tt(exp_tt),
        .gate_a(g0_a), .gate_b(g0_b), .gate_c(g0_c), .gate_o(g0_o),
        .busy(busy0), .done(done0), .tt(tt0), .err_cnt(err0), .pass(pass0),
        .state_dbg(st0)
    );

    gate_sweep_ctrl #(.SETTLE(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .exp_tt(exp_tt),
        .gate_a(g1_a), .gate_b(g1_b), .gate_c(g1_c), .gate_o(g1_o),
        .busy(busy1), .done(done1), .tt(tt1), .err_cnt(err1), .pass(pass1),
        .state_dbg(st1)
    );

    logic [2:0] o_gate, o_state;
    logic       o_busy, o_done, o_pass;
    logic [7:0] o_tt;
    logic [3:0] o_err;
    assign o_gate  = sel ? {g1_a, g1_b, g1_c} : {g0_a, g0_b, g0_c};
    assign o_busy  = sel ? busy1 : busy0;
    assign o_done  = sel ? done1 : done0;
    assign o_pass  = sel ? pass1 : pass0;
    assign o_tt    = sel ? tt1 : tt0;
    assign o_err   = sel ? err1 : err0;
    assign o_state = sel ? st1 : st0;

    task automatic chk(input string tag, input int m, input logic [7:0] obs,
                       input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cycle=%0d sel=%0d observed=%0h expected=%0h", tag, m, sel, obs, exp);
        end
    endtask

    task automatic chk_idle_zero(input string tag);
        chk({tag, "_gate"}, -1, 8'(o_gate), 8'd0);
        chk({tag, "_busy"}, -1, 8'(o_busy), 8'd0);
        chk({tag, "_done"}, -1, 8'(o_done), 8'd0);
        chk({tag, "_tt"},   -1, o_tt, 8'd0);
        chk({tag, "_err"},  -1, 8'(o_err), 8'd0);
        chk({tag, "_pass"}, -1, 8'(o_pass), 8'd0);
        chk({tag, "_state"}, -1, 8'(o_state), 8'd0);
    endtask

    // One sweep on the selected instance. Cycle m is the cycle after edge N+m,
    // where N is the edge that accepts start; vector k occupies m in
    // [k*(S+2), (k+1)*(S+2)-1], the DONE cycle is m = 8*(S+2).
    task automatic run_sweep(input logic [7:0] exp, input bit extra, input bit chain,
                             input bit started, input logic [7:0] chain_exp,
                             input logic [1:0] chain_mode);
        int         s, span, m_err;
        logic [7:0] m_tt;
        logic [2:0] vexp;
        s    = sel ? 1 : 2;
        span = 8 * (s + 2);
        for (int k = 0; k < 8; k++) m_tt[k] = gate_fn(sel ? 2'd0 : gmode, 3'(k), rand_tt);
        m_err = $countones(m_tt ^ exp);
        if (!started) begin
            @(negedge clk);
            start  = 1'b1;
            exp_tt = exp;
        end
        @(posedge clk);
        for (int m = 0; m <= span + 1; m++) begin
            @(negedge clk);
            if (m < span)       vexp = 3'(m / (s + 2));
            else if (m == span) vexp = 3'd7;
            else                vexp = 3'd0;
            chk("gate", m, 8'(o_gate), 8'(vexp));
            chk("busy", m, 8'(o_busy), 8'(m < span));
            chk("done", m, 8'(o_done), 8'(m == span));
            start = 1'b0;
            if (extra && m < span && $urandom_range(0, 3) == 0) begin
                start  = 1'b1;
                exp_tt = 8'($urandom);
            end
            if (extra && m == span) begin
                start  = 1'b1;
                exp_tt = ~exp;
            end
            if (m == span + 1) begin
                chk("tt", m, o_tt, m_tt);
                chk("err_cnt", m, 8'(o_err), 8'(m_err));
                chk("pass", m, 8'(o_pass), 8'(m_err == 0));
                if (chain) begin
                    start  = 1'b1;
                    exp_tt = chain_exp;
                    gmode  = chain_mode;
                end
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n   = 1'b0;
        start   = 1'b0;
        sel     = 1'b0;
        exp_tt  = 8'd0;
        gmode   = 2'd0;
        rand_tt = 8'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_idle_zero("reset");
        start = 1'b1;              // ignored while in reset
        @(negedge clk);
        chk_idle_zero("reset_start");
        start = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        chk_idle_zero("idle");

        // correct gate, matching / single-bit-off expectation
        run_sweep(8'h68, 1'b0, 1'b0, 1'b0, 8'h00, 2'd0);
        run_sweep(8'h69, 1'b0, 1'b0, 1'b0, 8'h00, 2'd0);

        // stuck-at-1 gate, then correct gate: results cleared on start
        gmode = 2'd1;
        run_sweep(8'h68, 1'b0, 1'b0, 1'b0, 8'h00, 2'd0);
        gmode = 2'd0;
        run_sweep(8'h68, 1'b0, 1'b0, 1'b0, 8'h00, 2'd0);

        // stray starts mid-sweep and in DONE, then a start in the first IDLE cycle
        run_sweep(8'h68, 1'b1, 1'b1, 1'b0, 8'h68, 2'd0);
        run_sweep(8'h68, 1'b0, 1'b0, 1'b1, 8'h00, 2'd0);

        // reset while vector 4 is settling
        @(negedge clk);
        start  = 1'b1;
        exp_tt = 8'h68;
        @(posedge clk);
        for (int m = 0; m <= 17; m++) begin
            @(negedge clk);
            start = 1'b0;
            if (m == 17) begin
                chk("pre_reset_tt", m, o_tt, 8'h08);
                rst_n = 1'b0;
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        chk_idle_zero("mid_reset");
        for (int m = 0; m < 3; m++) begin
            @(negedge clk);
            chk("post_reset_done", m, 8'(o_done), 8'd0);
            chk("post_reset_busy", m, 8'(o_busy), 8'd0);
        end
        run_sweep(8'h68, 1'b0, 1'b0, 1'b0, 8'h00, 2'd0);

        // random gate tables and expectations
        for (int r = 0; r < 6; r++) begin
            logic [7:0] e;
            rand_tt = 8'($urandom);
            gmode   = 2'd2;
            e       = ($urandom_range(0, 2) == 0) ? rand_tt : 8'($urandom);
            run_sweep(e, 1'($urandom_range(0, 1)), 1'b0, 1'b0, 8'h00, 2'd0);
        end
        gmode = 2'd0;

        // SETTLE=1 with a registered gate
        sel = 1'b1;
        @(negedge clk);
        chk_idle_zero("s1_idle");
        run_sweep(8'h68, 1'b0, 1'b0, 1'b0, 8'h00, 2'd0);
        run_sweep(8'($urandom), 1'b1, 1'b0, 1'b0, 8'h00, 2'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/gate_sweep_ctrl.md
# gate_sweep_ctrl

Sequencer that exhaustively exercises a 3-input combinational gate block, such as the team's exactly-two-of-three detector. It drives all 8 input combinations in order, waits a programmable settle time, and captures the gate output into an 8-bit truth-table register. It compares each captured bit against an expected table and reports a mismatch count and a pass flag. It sits between the bench/top-level control logic and one gate instance, owning that gate's inputs for the duration of a sweep.

## Interface
- SETTLE, 2, cycles between driving a vector and sampling the gate output; legal range 1..15.

- clk  in  1  single clock; all state changes on rising edge
- rst_n  in  1  reset, synchronous, active-low
- start  in  1  sweep request; sampled only in IDLE
- exp_tt  in  8  expected truth table; bit k = expected output for input index k; latched on accepted start
- gate_a  out  1  gate input a (MSB of index)
- gate_b  out  1  gate input b
- gate_c  out  1  gate input c (LSB of index)
- gate_o  in  1  gate output under test
- busy  out  1  high while a sweep is in progress
- done  out  1  one-cycle pulse marking sweep completion
- tt  out  8  captured truth table; bit k = gate_o sampled for index k
- err_cnt  out  4  number of bits where captured differs from expected (0..8)
- pass  out  1  high when the last completed sweep had err_cnt == 0

## Operation
- Reset (rst_n low at an edge): state IDLE. gate_a/b/c, busy, done, tt, err_cnt, pass, the internal index and the settle counter all go to 0. start is ignored while rst_n is low.
- State machine: IDLE, DRIVE, SETTLE, SAMPLE, DONE.
- IDLE:
  - gate inputs hold 0; busy = 0.
  - On start = 1: latch exp_tt, clear tt, err_cnt and pass, set idx = 0, go to DRIVE.
- DRIVE (1 cycle):
  - {gate_a, gate_b, gate_c} = idx[2:0].
  - Load the settle counter with SETTLE, go to SETTLE.
- SETTLE (SETTLE cycles):
  - Inputs held; the counter decrements each cycle.
  - Go to SAMPLE when the counter reaches 1.
- SAMPLE (1 cycle):
  - tt[idx] <= gate_o.
  - If gate_o != exp_latched[idx], err_cnt <= err_cnt + 1.
  - If idx == 7, go to DONE; otherwise idx <= idx + 1 and go to DRIVE.
- DONE (1 cycle):
  - done = 1; pass <= (err_cnt == 0), using the final count including the last sample.
  - Go to IDLE; gate inputs return to 0 on entry to IDLE.
- busy = 1 in DRIVE, SETTLE and SAMPLE; 0 in IDLE and DONE.
- Gate inputs are stable from DRIVE through SAMPLE of each vector and change only on entry to DRIVE or IDLE.
- tt, err_cnt and pass hold their values after DONE until the next accepted start.
- err_cnt cannot exceed 8, so no saturation logic is required.
- Changes to exp_tt during a sweep have no effect.

## Timing
- Per vector: SETTLE + 2 cycles. Full sweep: 8·(SETTLE + 2) cycles, then 1 DONE cycle.
- Start accepted at edge N:
  - busy rises after edge N.
  - Vector k is sampled at edge N + (k+1)·(SETTLE + 2).
  - done is high for the one cycle following edge N + 8·(SETTLE + 2).
  - With SETTLE = 2, done is high for the cycle after edge N + 32.
- start while busy or during DONE: ignored, with no queuing.
- start in the first IDLE cycle after DONE: accepted.
- rst_n low mid-sweep: at that edge all outputs return to their reset values and the partial results are discarded. done is not pulsed.
- Gate output must settle within SETTLE cycles of DRIVE. A registered gate model with 1-cycle latency is valid for SETTLE ≥ 1.

## Test plan
- Correct exactly-two-of-three model, exp_tt = 8'h68, SETTLE = 2, start pulse -> gate inputs step through 000..111, tt = 8'h68, err_cnt = 0, pass = 1, done one cycle after edge N+32, busy low in that cycle.
- Same model, exp_tt = 8'h69 -> tt = 8'h68, err_cnt = 1, pass = 0.
- gate_o tied to 1, exp_tt = 8'h68 -> tt = 8'hFF, err_cnt = 5, pass = 0; a second sweep with the correct model -> err_cnt = 0, pass = 1 (counters are cleared on start).
- Extra start pulses at random cycles during a sweep, and one in the DONE cycle -> exactly one done pulse, results identical to the single-start case; a start in the following IDLE cycle begins a new sweep.
- rst_n low for 1 cycle while idx = 4 in SETTLE -> next cycle tt = 0, err_cnt = 0, pass = 0, busy = 0, gate inputs = 000, no done pulse; a fresh start completes with tt = 8'h68.
- SETTLE = 1 with a registered 1-cycle-latency gate model, exp_tt = 8'h68 -> pass = 1, done one cycle after edge N+24.
